// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: unit codes, FSM states,
// flag bit positions and the ALU datapath width.
package alu_seq_pkg;

  localparam int ALU_W  = 8;
  localparam int FLAG_W = 6;

  // Bit positions inside the 6-bit flag vector
  localparam int FLAG_A_BIG = 5;
  localparam int FLAG_B_BIG = 4;
  localparam int FLAG_EQ    = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_SHIFT = 2'b10,
    UNIT_RSVD  = 2'b11
  } unit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Valid/ready command front end for the 8-bit ALU: issues one operation,
// waits out the ALU output register, and returns result plus flags.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [3:0]        i_cmd_op,
  input  logic [ALU_W-1:0]  i_cmd_a,
  input  logic [ALU_W-1:0]  i_cmd_b,
  input  logic              i_cmd_chain,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [ALU_W-1:0]  o_rsp_result,
  output logic [FLAG_W-1:0] o_rsp_flags,
  output logic              o_rsp_err,
  output logic [ALU_W-1:0]  o_alu_A,
  output logic [ALU_W-1:0]  o_alu_B,
  output logic [1:0]        o_alu_S2_S3,
  output logic              o_alu_S1,
  output logic              o_alu_s2,
  input  logic [ALU_W-1:0]  i_alu_F,
  input  logic [FLAG_W-1:0] i_alu_flags,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_op_count
);

  state_t             r_state;
  state_t             w_state_next;
  unit_t              r_unit;
  logic [1:0]         r_func;
  logic [ALU_W-1:0]   r_a;
  logic [ALU_W-1:0]   r_b;
  logic [ALU_W-1:0]   r_last;
  logic [ALU_W-1:0]   r_rsp_result;
  logic [FLAG_W-1:0]  r_rsp_flags;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_count;
  unit_t              w_cmd_unit;
  logic               w_accept;

  assign w_cmd_unit = unit_t'(i_cmd_op[3:2]);
  assign w_accept   = (r_state == ST_IDLE) && i_cmd_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_cmd_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_alu_A      = '0;
    o_alu_B      = '0;
    o_alu_S2_S3  = '0;
    o_alu_S1     = 1'b0;
    o_alu_s2     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid)
          w_state_next = (w_cmd_unit == UNIT_RSVD) ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE, ST_WAIT: begin
        // Operands stay on the bus through WAIT so the flags match the captured F
        o_alu_A      = r_a;
        o_alu_B      = r_b;
        o_alu_S2_S3  = r_func;
        o_alu_S1     = (r_unit == UNIT_SHIFT);
        o_alu_s2     = (r_unit != UNIT_ARITH);
        w_state_next = (r_state == ST_ISSUE) ? ST_WAIT : ST_RESP;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_unit       <= UNIT_ARITH;
      r_func       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_last       <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_accept) begin
        r_unit <= w_cmd_unit;
        r_func <= i_cmd_op[1:0];
        r_a    <= i_cmd_chain ? r_last : i_cmd_a;
        r_b    <= i_cmd_b;
        if (w_cmd_unit == UNIT_RSVD) begin
          r_rsp_result <= '0;
          r_rsp_flags  <= '0;
          r_rsp_err    <= 1'b1;
        end
      end
      if (r_state == ST_WAIT) begin
        r_rsp_result <= i_alu_F;
        r_rsp_flags  <= i_alu_flags;
        r_rsp_err    <= 1'b0;
        r_last       <= i_alu_F;
        r_count      <= r_count + 1'b1;
      end
    end
  end

  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_rsp_err    = r_rsp_err;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_op_count   = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer: two instances (16-bit
// and 2-bit counters) share one command stream, each with an XOR ALU stub.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       cmd_chain;
  logic       rsp_ready;

  logic       cmd_ready, rsp_valid, rsp_err, alu_S1, alu_s2, busy;
  logic [7:0] rsp_result, alu_A, alu_B, alu_F;
  logic [5:0] rsp_flags, alu_flags;
  logic [1:0] alu_S2_S3;
  logic [15:0] op_count;

  logic       cmd_ready2, rsp_valid2, rsp_err2, alu_S1_2, alu_s2_2, busy2;
  logic [7:0] rsp_result2, alu_A2, alu_B2, alu_F2;
  logic [5:0] rsp_flags2, alu_flags2;
  logic [1:0] alu_S2_S3_2;
  logic [1:0] op_count2;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt   = 0;
  logic [7:0] m_last = 8'h00;
  logic [7:0] last_res;
  logic [5:0] last_flg;
  logic       last_err;

  always #5 clk = ~clk;

  // ALU stubs: F registers A^B, flags combinational from current operands
  always @(posedge clk) alu_F  <= alu_A ^ alu_B;
  always @(posedge clk) alu_F2 <= alu_A2 ^ alu_B2;
  assign alu_flags  = {alu_A > alu_B, alu_A < alu_B, alu_A == alu_B, (alu_A ^ alu_B) == 8'h00, 2'b00};
  assign alu_flags2 = {alu_A2 > alu_B2, alu_A2 < alu_B2, alu_A2 == alu_B2, (alu_A2 ^ alu_B2) == 8'h00, 2'b00};

  alu_op_sequencer #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_chain(cmd_chain),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_result(rsp_result),
    .o_rsp_flags(rsp_flags), .o_rsp_err(rsp_err), .o_alu_A(alu_A), .o_alu_B(alu_B),
    .o_alu_S2_S3(alu_S2_S3), .o_alu_S1(alu_S1), .o_alu_s2(alu_s2), .i_alu_F(alu_F),
    .i_alu_flags(alu_flags), .o_busy(busy), .o_op_count(op_count)
  );

  alu_op_sequencer #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready2),
    .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_chain(cmd_chain),
    .o_rsp_valid(rsp_valid2), .i_rsp_ready(rsp_ready), .o_rsp_result(rsp_result2),
    .o_rsp_flags(rsp_flags2), .o_rsp_err(rsp_err2), .o_alu_A(alu_A2), .o_alu_B(alu_B2),
    .o_alu_S2_S3(alu_S2_S3_2), .o_alu_S1(alu_S1_2), .o_alu_s2(alu_s2_2), .i_alu_F(alu_F2),
    .i_alu_flags(alu_flags2), .o_busy(busy2), .o_op_count(op_count2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check_val({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_val({tag, "_rsp"}, {17'd0, rsp_result, rsp_flags, rsp_err}, 32'd0);
    check_val({tag, "_alu"}, {13'd0, alu_A, alu_B, alu_S2_S3, alu_S1, alu_s2}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_op_count"}, {16'd0, op_count}, 32'd0);
    check_val({tag, "_op_count2"}, {30'd0, op_count2}, 32'd0);
  endtask

  // One full transaction; expected values come from the operation rules alone
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic chain, input int hold);
    logic [1:0] unit;
    logic [7:0] a_eff, e_res;
    logic [5:0] e_flg;
    logic       e_err;
    int         lat, e_lat;
    unit  = op[3:2];
    a_eff = chain ? m_last : a;
    if (unit == 2'b11) begin
      e_res = 8'h00; e_flg = 6'h00; e_err = 1'b1; e_lat = 1;
    end else begin
      e_res = a_eff ^ b;
      e_flg = {a_eff > b, a_eff < b, a_eff == b, e_res == 8'h00, 2'b00};
      e_err = 1'b0; e_lat = 3;
      m_last = e_res;
      m_cnt++;
    end
    @(negedge clk);
    check_val("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_chain = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      if (lat == 1 || lat == 2) begin
        check_val("issue_alu_A", {24'd0, alu_A}, {24'd0, a_eff});
        check_val("issue_alu_B", {24'd0, alu_B}, {24'd0, b});
        check_val("issue_sel", {28'd0, alu_S2_S3, alu_S1, alu_s2},
                  {28'd0, op[1:0], unit == 2'b10, unit != 2'b00});
        check_val("issue_busy_rdy", {30'd0, busy, cmd_ready}, 32'd2);
      end
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", lat, e_lat);
    check_val("rsp_result", {24'd0, rsp_result}, {24'd0, e_res});
    check_val("rsp_flags", {26'd0, rsp_flags}, {26'd0, e_flg});
    check_val("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
    check_val("op_count", {16'd0, op_count}, {16'd0, m_cnt[15:0]});
    check_val("op_count2", {30'd0, op_count2}, m_cnt % 4);
    check_val("resp_alu_idle", {13'd0, alu_A, alu_B, alu_S2_S3, alu_S1, alu_s2}, 32'd0);
    last_res = rsp_result; last_flg = rsp_flags; last_err = rsp_err;
    $display("[TB] op=%b a=%02h b=%02h chain=%0d -> res=%02h flags=%06b err=%0d cnt=%0d lat=%0d",
             op, a, b, chain, rsp_result, rsp_flags, rsp_err, op_count, lat);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_val("hold_valid_rdy", {30'd0, rsp_valid, cmd_ready}, 32'd2);
      check_val("hold_stable", {17'd0, rsp_result, rsp_flags, rsp_err},
                {17'd0, e_res, e_flg, e_err});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val("post_hs_valid_rdy", {30'd0, rsp_valid, cmd_ready}, 32'd1);
  endtask

  initial begin
    int seq [5] = '{1, 2, 3, 0, 1};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_chain = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(4'b0100, 8'h0F, 8'h01, 1'b0, 0);
    check_val("tp1_result", {24'd0, last_res}, 32'h0E);
    check_val("tp1_flags", {26'd0, last_flg}, 32'h20);
    check_val("tp1_count", {16'd0, op_count}, 32'd1);

    run_cmd(4'b0001, 8'h55, 8'h55, 1'b0, 0);
    check_val("tp2_flags", {26'd0, last_flg}, 32'h0C);
    run_cmd(4'b0010, 8'hAA, 8'hFF, 1'b1, 0);
    check_val("tp2_chain_res", {24'd0, last_res}, 32'hFF);

    run_cmd(4'b1100, 8'h12, 8'h34, 1'b0, 0);
    check_val("tp3_err", {31'd0, last_err}, 32'd1);
    check_val("tp3_count", {16'd0, op_count}, 32'd3);

    run_cmd(4'b1011, 8'h81, 8'h7E, 1'b0, 5);

    for (int i = 0; i < 30; i++)
      run_cmd(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    // Reset while the ALU result is being waited out
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 8'h3C; cmd_b = 8'h0F; cmd_chain = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0; m_last = 8'h00;

    for (int i = 0; i < 5; i++) begin
      run_cmd(4'($urandom_range(0, 11)), 8'($urandom), 8'($urandom), 1'($urandom), 0);
      check_val("wrap_seq", {30'd0, op_count2}, seq[i]);
    end
    check_val("post_rst_count", {16'd0, op_count}, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-driven front end for the 8-bit ALU datapath: accepts operations over a valid/ready command channel, drives the ALU operand and select inputs, waits out the ALU output register, and returns the registered result plus the six comparison/status flags over a valid/ready response channel. It is the initiator side of the ALU's operand/select interface. It sits between a host or test controller and the ALU top level, and supports chaining the previous result back in as operand A.

## Interface
- CNT_W, 16, width of the completed-operation counter
- CLK  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  [3:2] unit (00 arith, 01 logic, 10 shift, 11 reserved); [1:0] function → ALU S2_S3
- cmd_a, cmd_b  in  8  operands
- cmd_chain  in  1  1 = use last good result as A, ignore cmd_a
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  8  captured ALU F
- rsp_flags  out  6  {A_bigger, B_bigger, A_equal_B, flag_zero, carry_out, over_flow}
- rsp_err  out  1  reserved opcode; result and flags are 0
- alu_A, alu_B  out  8  to ALU A, B
- alu_S2_S3  out  2  to ALU S2_S3
- alu_S1  out  1  0 = logic, 1 = shift
- alu_s2  out  1  0 = arithmetic, 1 = S1 path
- alu_F  in  8  ALU registered result
- alu_flags  in  6  ALU flags, same order as rsp_flags, combinational from current operands
- busy  out  1  state ≠ IDLE
- op_count  out  CNT_W  successful operations, wraps to 0

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch op/operands/chain.
  - Reserved unit → RESP with rsp_err=1.
  - Otherwise → ISSUE.
- ISSUE: drive alu_* from the latched command. Select mapping: arith → s2=0, S1=0; logic → s2=1, S1=0; shift → s2=1, S1=1. The ALU register samples at the end of this cycle. → WAIT.
- WAIT: alu_* held unchanged. At the end of the cycle, capture alu_F into rsp_result and alu_flags into rsp_flags, set rsp_err=0, update last_result, and increment op_count. → RESP.
- RESP: rsp_valid=1. Result, flags and err stay stable until rsp_ready. On rsp_valid & rsp_ready → IDLE.
- In IDLE and RESP, alu_A/alu_B/alu_S2_S3/alu_S1/alu_s2 are driven to 0.
- Chain: A = last_result, the most recent successful capture (reset value 0). Error responses do not update last_result.
- cmd_ready is 0 outside IDLE, so there is no command buffering and no command is lost.

## Timing
- Reset values:
  - State IDLE; cmd_ready=1.
  - rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0.
  - All alu_* outputs 0; busy=0; op_count=0; last_result=0.
- Reset asserted mid-operation: the in-flight command and any pending response are dropped, and every output takes its reset value immediately.
- Latency for a valid op:
  - Command accepted at edge 0.
  - ISSUE is cycle 1, WAIT is cycle 2.
  - rsp_valid is high from cycle 3.
- Latency for a reserved op: rsp_valid is high from cycle 1.
- If rsp_ready is already high, rsp_valid lasts one cycle and cmd_ready returns in the next cycle. Issue rate is one command per 4 cycles maximum.
- rsp_ready while rsp_valid=0 is ignored. cmd_valid while cmd_ready=0 is ignored, and the command must be held by the source.
- op_count at 2^CNT_W−1 wraps to 0 on the next success.

## Structure
- Package alu_seq_pkg contains:
  - unit codes (ARITH, LOGIC, SHIFT, RSVD)
  - state enum
  - flag bit indices for the 6-bit flag vector
  - the ALU data width constant 8
- Single module; no sub-module required. The FSM, command latch and response register all sit in one always block set.

## Test plan
- Bench ALU stub: F registers A^B each clock; flags = {A>B, A<B, A==B, (A^B)==0, 0, 0}.
- cmd op=0100 A=8'h0F B=8'h01 → rsp at cycle 3: result 8'h0E, flags 6'b100000, err 0, op_count 1.
- cmd A=8'h55 B=8'h55, then a chained cmd with B=8'hFF:
  - first response is result 8'h00 with flags 6'b001100;
  - second drives alu_A=8'h00 and returns result 8'hFF.
- cmd op=1100 → rsp_valid at cycle 1, err 1, result 0, flags 0; op_count unchanged and no nonzero alu_* activity.
- Hold rsp_ready=0 for 5 cycles: rsp stays stable and cmd_ready stays 0. Assert rsp_ready: rsp_valid drops next cycle and cmd_ready rises.
- Assert rst_n=0 during WAIT: all outputs return to reset values. After release, a new cmd completes normally with op_count=1.
- CNT_W=2 instance, 5 successful ops → op_count sequence 1, 2, 3, 0, 1.
